// File: rtl/vga_ram_write_arbiter_if.sv
// ----------------------------------------------------------------------------
// vga_ram_write_arbiter_if
// Bundles the signals between the pixel-write requesters (plus the clear
// control and the frame RAM write port) and vga_ram_write_arbiter.
//   master : requester / control side (drives requests, window, clear)
//   slave  : arbiter side (drives ready, busy, RAM write port, drop pulse)
// Packing: channel i coordinates live at req_x/req_y[11i+10:11i].
// ----------------------------------------------------------------------------
interface vga_ram_write_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 19
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*11-1:0] req_x;
    logic [NUM_REQ*11-1:0] req_y;
    logic [NUM_REQ-1:0]    req_pixel;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  write_window;
    logic                  clear_start;
    logic                  clear_value;
    logic                  clear_busy;
    logic                  ram_we;
    logic [ADDR_W-1:0]     ram_write_address;
    logic                  ram_d;
    logic                  drop_pulse;

    modport master (
        output req_valid, req_x, req_y, req_pixel, write_window,
               clear_start, clear_value,
        input  req_ready, clear_busy, ram_we, ram_write_address, ram_d,
               drop_pulse
    );

    modport slave (
        input  req_valid, req_x, req_y, req_pixel, write_window,
               clear_start, clear_value,
        output req_ready, clear_busy, ram_we, ram_write_address, ram_d,
               drop_pulse
    );
endinterface

// File: rtl/vga_ram_write_arbiter.sv
// ----------------------------------------------------------------------------
// vga_ram_write_arbiter
// Owns the write port of the 1-bit H_RES x V_RES background frame RAM and
// shares it round-robin between NUM_REQ pixel-write requesters. Converts
// (x,y) to y*H_RES+x, drops out-of-range requests (drop_pulse), gates all
// writes with write_window, and provides a full-frame clear sequencer.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : slave side of vga_ram_write_arbiter_if (requests, ready, window,
//           clear control/busy, registered RAM write port, drop pulse)
// ----------------------------------------------------------------------------
module vga_ram_write_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int H_RES   = 800,
    parameter int V_RES   = 480,
    parameter int ADDR_W  = 19
) (
    input  logic                    clk,
    input  logic                    reset,
    vga_ram_write_arbiter_if.slave  bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [10:0]       X_LIM     = 11'(H_RES);
    localparam logic [10:0]       Y_LIM     = 11'(V_RES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_reg;
    logic [PTR_W-1:0]  ptr_reg;
    logic [ADDR_W-1:0] clear_cnt_reg;
    logic              clear_val_reg;
    logic              ram_we_reg;
    logic [ADDR_W-1:0] ram_addr_reg;
    logic              ram_d_reg;
    logic              drop_reg;

    // Per-channel coordinate views of the packed buses.
    logic [10:0] x_arr [NUM_REQ];
    logic [10:0] y_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign x_arr[gi] = bus.req_x[11*gi +: 11];
            assign y_arr[gi] = bus.req_y[11*gi +: 11];
        end
    endgenerate

    // Round-robin search: first valid channel starting at ptr_reg, wrapping.
    logic             grant_found;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W-1:0] cand_idx;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_idx = PTR_W'((int'(ptr_reg) + k) % NUM_REQ);
            if (!grant_found && bus.req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // clear_start pre-empts every requester in the cycle it is seen.
    logic grant_ok;
    assign grant_ok = (state_reg == IDLE) && bus.write_window &&
                      !bus.clear_start && grant_found;

    always_comb begin
        bus.req_ready = '0;
        if (grant_ok) begin
            bus.req_ready[grant_idx] = 1'b1;
        end
    end

    logic [10:0]       sel_x;
    logic [10:0]       sel_y;
    logic              sel_in_range;
    logic [ADDR_W-1:0] sel_addr;
    logic [PTR_W-1:0]  ptr_next;

    assign sel_x        = x_arr[grant_idx];
    assign sel_y        = y_arr[grant_idx];
    assign sel_in_range = (sel_x < X_LIM) && (sel_y < Y_LIM);
    assign sel_addr     = ADDR_W'(sel_y) * ADDR_W'(H_RES) + ADDR_W'(sel_x);
    assign ptr_next     = PTR_W'((int'(grant_idx) + 1) % NUM_REQ);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            clear_cnt_reg <= '0;
            clear_val_reg <= 1'b0;
            ram_we_reg    <= 1'b0;
            ram_addr_reg  <= '0;
            ram_d_reg     <= 1'b0;
            drop_reg      <= 1'b0;
        end else begin
            // Strobes default low; address/data hold between writes.
            ram_we_reg <= 1'b0;
            drop_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.clear_start) begin
                        state_reg     <= CLEAR;
                        clear_cnt_reg <= '0;
                        clear_val_reg <= bus.clear_value;
                    end else if (grant_ok) begin
                        ptr_reg <= ptr_next;
                        if (sel_in_range) begin
                            ram_we_reg   <= 1'b1;
                            ram_addr_reg <= sel_addr;
                            ram_d_reg    <= bus.req_pixel[grant_idx];
                        end else begin
                            drop_reg <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    if (bus.write_window) begin
                        ram_we_reg   <= 1'b1;
                        ram_addr_reg <= clear_cnt_reg;
                        ram_d_reg    <= clear_val_reg;
                        if (clear_cnt_reg == LAST_ADDR) begin
                            // Leaving here makes busy fall alongside the last ram_we.
                            state_reg     <= IDLE;
                            clear_cnt_reg <= '0;
                        end else begin
                            clear_cnt_reg <= clear_cnt_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.clear_busy        = (state_reg == CLEAR);
    assign bus.ram_we            = ram_we_reg;
    assign bus.ram_write_address = ram_addr_reg;
    assign bus.ram_d             = ram_d_reg;
    assign bus.drop_pulse        = drop_reg;
endmodule

// File: tb/tb_vga_ram_write_arbiter.sv
// ----------------------------------------------------------------------------
// tb_vga_ram_write_arbiter
// Directed bench. dut_a: 800x480 frame for grant, window and range checks.
// dut_b: 8x4 frame for the clear sequencer and reset-during-clear.
// Inputs change 1 time unit after the rising edge; outputs are sampled
// 1 time unit after that (combinational ready) or after the next edge
// (registered outputs).
// ----------------------------------------------------------------------------
module tb_vga_ram_write_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    vga_ram_write_arbiter_if #(.NUM_REQ(2), .ADDR_W(19)) a_if ();
    vga_ram_write_arbiter_if #(.NUM_REQ(2), .ADDR_W(6))  b_if ();

    vga_ram_write_arbiter #(.NUM_REQ(2), .H_RES(800), .V_RES(480), .ADDR_W(19)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if)
    );

    vga_ram_write_arbiter #(.NUM_REQ(2), .H_RES(8), .V_RES(4), .ADDR_W(6)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_a(input int ch, input logic v, input int x, input int y, input logic p);
        a_if.req_valid[ch]        = v;
        a_if.req_x[11*ch +: 11]   = 11'(x);
        a_if.req_y[11*ch +: 11]   = 11'(y);
        a_if.req_pixel[ch]        = p;
    endtask

    task automatic set_b(input int ch, input logic v, input int x, input int y, input logic p);
        b_if.req_valid[ch]        = v;
        b_if.req_x[11*ch +: 11]   = 11'(x);
        b_if.req_y[11*ch +: 11]   = 11'(y);
        b_if.req_pixel[ch]        = p;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    int exp_addr;
    int c;

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        a_if.req_valid = '0; a_if.req_x = '0; a_if.req_y = '0; a_if.req_pixel = '0;
        a_if.write_window = 1'b0; a_if.clear_start = 1'b0; a_if.clear_value = 1'b0;
        b_if.req_valid = '0; b_if.req_x = '0; b_if.req_y = '0; b_if.req_pixel = '0;
        b_if.write_window = 1'b0; b_if.clear_start = 1'b0; b_if.clear_value = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_we",    32'(a_if.ram_we), 0);
        chk("rst_addr",  32'(a_if.ram_write_address), 0);
        chk("rst_d",     32'(a_if.ram_d), 0);
        chk("rst_busy",  32'(a_if.clear_busy), 0);
        chk("rst_drop",  32'(a_if.drop_pulse), 0);
        chk("rst_ready", 32'(a_if.req_ready), 0);
        reset = 1'b0;

        // Single write: (10,2) -> 1610
        a_if.write_window = 1'b1;
        set_a(0, 1'b1, 10, 2, 1'b1);
        settle();
        chk("single_ready", 32'(a_if.req_ready), 32'h1);
        tick();
        chk("single_we",   32'(a_if.ram_we), 1);
        chk("single_addr", 32'(a_if.ram_write_address), 1610);
        chk("single_d",    32'(a_if.ram_d), 1);
        set_a(0, 1'b0, 10, 2, 1'b1);
        tick();
        chk("single_we_off",    32'(a_if.ram_we), 0);
        chk("single_addr_hold", 32'(a_if.ram_write_address), 1610);

        // Round robin from p=0: ch0 (1,0,d=1) -> 1, ch1 (2,1,d=0) -> 802
        pulse_reset();
        a_if.write_window = 1'b1;
        set_a(0, 1'b1, 1, 0, 1'b1);
        set_a(1, 1'b1, 2, 1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            settle();
            chk($sformatf("rr_ready_%0d", k), 32'(a_if.req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            chk($sformatf("rr_we_%0d", k),   32'(a_if.ram_we), 1);
            chk($sformatf("rr_addr_%0d", k), 32'(a_if.ram_write_address), (k % 2 == 0) ? 1 : 802);
            chk($sformatf("rr_d_%0d", k),    32'(a_if.ram_d), (k % 2 == 0) ? 1 : 0);
        end
        a_if.req_valid = '0;
        tick();
        chk("rr_we_off", 32'(a_if.ram_we), 0);

        // Window gating, corner pixel (799,479) -> 383999 on ch1 (p=0, wraps)
        a_if.write_window = 1'b0;
        set_a(1, 1'b1, 799, 479, 1'b1);
        for (int k = 0; k < 5; k++) begin
            settle();
            chk($sformatf("win_ready_%0d", k), 32'(a_if.req_ready), 0);
            tick();
            chk($sformatf("win_we_%0d", k), 32'(a_if.ram_we), 0);
        end
        a_if.write_window = 1'b1;
        settle();
        chk("win_open_ready", 32'(a_if.req_ready), 32'h2);
        tick();
        chk("corner_we",   32'(a_if.ram_we), 1);
        chk("corner_addr", 32'(a_if.ram_write_address), 383999);
        chk("corner_d",    32'(a_if.ram_d), 1);
        set_a(1, 1'b0, 0, 0, 1'b0);

        // Out of range: x=800, then y=480
        set_a(0, 1'b1, 800, 0, 1'b1);
        settle();
        chk("oorx_ready", 32'(a_if.req_ready), 32'h1);
        tick();
        chk("oorx_drop", 32'(a_if.drop_pulse), 1);
        chk("oorx_we",   32'(a_if.ram_we), 0);
        set_a(0, 1'b1, 0, 480, 1'b1);
        settle();
        chk("oory_ready", 32'(a_if.req_ready), 32'h1);
        tick();
        chk("oory_drop", 32'(a_if.drop_pulse), 1);
        chk("oory_we",   32'(a_if.ram_we), 0);
        chk("oory_addr_hold", 32'(a_if.ram_write_address), 383999);
        set_a(0, 1'b0, 0, 0, 1'b0);
        tick();
        chk("drop_off", 32'(a_if.drop_pulse), 0);

        // Clear on 8x4 frame while ch0 (3,1)->11 waits
        b_if.write_window = 1'b1;
        set_b(0, 1'b1, 3, 1, 1'b0);
        b_if.clear_start = 1'b1;
        b_if.clear_value = 1'b1;
        settle();
        chk("clr_start_ready", 32'(b_if.req_ready), 0);
        tick();
        b_if.clear_start = 1'b0;
        b_if.clear_value = 1'b0;
        chk("clr_busy_on", 32'(b_if.clear_busy), 1);
        chk("clr_we_first", 32'(b_if.ram_we), 0);
        exp_addr = 0;
        c = 0;
        while (exp_addr < 32 && c < 200) begin
            b_if.write_window = (c % 2 == 0);
            settle();
            chk($sformatf("clr_ready_%0d", c), 32'(b_if.req_ready), 0);
            chk($sformatf("clr_busy_%0d", c),  32'(b_if.clear_busy), 1);
            tick();
            if (c % 2 == 0) begin
                chk($sformatf("clr_we_%0d", c),   32'(b_if.ram_we), 1);
                chk($sformatf("clr_addr_%0d", c), 32'(b_if.ram_write_address), 32'(exp_addr));
                chk($sformatf("clr_d_%0d", c),    32'(b_if.ram_d), 1);
                exp_addr++;
            end else begin
                chk($sformatf("clr_stall_we_%0d", c), 32'(b_if.ram_we), 0);
            end
            c++;
        end
        chk("clr_count", 32'(exp_addr), 32);
        b_if.write_window = 1'b1;
        settle();
        chk("clr_busy_fall", 32'(b_if.clear_busy), 0);
        chk("clr_last_we",   32'(b_if.ram_we), 1);
        chk("clr_after_ready", 32'(b_if.req_ready), 32'h1);
        tick();
        chk("clr_after_we",   32'(b_if.ram_we), 1);
        chk("clr_after_addr", 32'(b_if.ram_write_address), 11);
        chk("clr_after_d",    32'(b_if.ram_d), 0);
        b_if.req_valid = '0;

        // Reset mid-clear at counter 12 (p was 1 after the ch0 grant)
        b_if.clear_start = 1'b1;
        settle();
        tick();
        b_if.clear_start = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        chk("mid_busy",    32'(b_if.clear_busy), 1);
        chk("mid_addr_11", 32'(b_if.ram_write_address), 11);
        reset = 1'b1;
        settle();
        chk("arst_busy", 32'(b_if.clear_busy), 0);
        chk("arst_we",   32'(b_if.ram_we), 0);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("post_busy_%0d", k), 32'(b_if.clear_busy), 0);
            chk($sformatf("post_we_%0d", k),   32'(b_if.ram_we), 0);
        end
        set_b(0, 1'b1, 0, 0, 1'b1);
        set_b(1, 1'b1, 1, 0, 1'b1);
        settle();
        chk("post_ptr0_ready", 32'(b_if.req_ready), 32'h1);
        tick();
        chk("post_we",   32'(b_if.ram_we), 1);
        chk("post_addr", 32'(b_if.ram_write_address), 0);
        b_if.req_valid = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
